// File: rtl/stopwatch_multi.sv
// Multi-digit BCD stopwatch with run/pause, digit-by-digit preset and lap hold.
// Four active-low buttons are synchronized and edge-detected on clk100_i.
module stopwatch_multi #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1000000
) (
    input  logic                  clk100_i,
    input  logic                  rst_i,
    input  logic                  start_stop_i,
    input  logic                  set_i,
    input  logic                  change_i,
    input  logic                  lap_i,
    output logic [7*DIGITS-1:0]   hex_o,
    output logic                  running_o,
    output logic                  set_mode_o,
    output logic [2:0]            sel_o,
    output logic                  lap_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SET  = 2'd2;

    localparam int              PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [2:0]      SEL_LAST  = 3'(DIGITS - 1);
    localparam int              CW        = 4 * DIGITS;

    // Button vector order: {start_stop, set, lap, change}.
    logic [3:0] btn_raw;
    logic [3:0] sync1_q, sync2_q, hist_q;
    logic [3:0] press;
    logic       press_ss, press_set, press_lap, press_chg;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] lap_val_q, lap_val_d;
    logic          lap_q, lap_d;
    logic [2:0]    sel_q, sel_d;

    logic [CW-1:0] count_inc;
    logic [CW-1:0] count_edit;
    logic [CW-1:0] disp;
    logic          inc_carry;

    assign btn_raw   = {start_stop_i, set_i, lap_i, change_i};
    assign press     = hist_q & ~sync2_q;
    assign press_ss  = press[3];
    assign press_set = press[2];
    assign press_lap = press[1];
    assign press_chg = press[0];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Decimal ripple increment of the whole count; all-9s rolls to all-0s.
    always_comb begin
        count_inc = count_q;
        inc_carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (inc_carry) begin
                if (count_q[4*k +: 4] == 4'd9) begin
                    count_inc[4*k +: 4] = 4'd0;
                end else begin
                    count_inc[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                    inc_carry = 1'b0;
                end
            end
        end
    end

    // Selected digit steps 0..9 on its own, never carrying into neighbours.
    always_comb begin
        count_edit = count_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (sel_q == 3'(k)) begin
                count_edit[4*k +: 4] = (count_q[4*k +: 4] == 4'd9) ? 4'd0
                                                                   : count_q[4*k +: 4] + 4'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        count_d   = count_q;
        lap_val_d = lap_val_q;
        lap_d     = lap_q;
        sel_d     = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (press_ss) begin
                    state_d = ST_RUN;
                end else if (press_set) begin
                    state_d = ST_SET;
                    sel_d   = 3'd0;
                end else if (press_lap) begin
                    if (lap_q) begin
                        lap_d = 1'b0;
                    end else begin
                        count_d = '0;
                        presc_d = '0;
                    end
                end
            end
            ST_RUN: begin
                // The tick applies even on the cycle a stop press lands.
                if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    count_d = count_inc;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (press_ss) begin
                    state_d = ST_IDLE;
                end else if (press_lap) begin
                    lap_d = ~lap_q;
                    if (!lap_q) begin
                        lap_val_d = count_q;
                    end
                end
            end
            ST_SET: begin
                if (press_set) begin
                    if (sel_q == SEL_LAST) begin
                        state_d = ST_IDLE;
                        sel_d   = 3'd0;
                    end else begin
                        sel_d = sel_q + 3'd1;
                    end
                end else if (press_chg) begin
                    count_d = count_edit;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            hist_q    <= '1;
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            lap_val_q <= '0;
            lap_q     <= 1'b0;
            sel_q     <= 3'd0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            hist_q    <= sync2_q;
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            lap_val_q <= lap_val_d;
            lap_q     <= lap_d;
            sel_q     <= sel_d;
        end
    end

    assign disp = lap_q ? lap_val_q : count_q;

    always_comb begin
        hex_o = '1;
        for (int k = 0; k < DIGITS; k++) begin
            hex_o[7*k +: 7] = seg7(disp[4*k +: 4]);
        end
    end

    assign running_o  = (state_q == ST_RUN);
    assign set_mode_o = (state_q == ST_SET);
    assign sel_o      = sel_q;
    assign lap_o      = lap_q;
endmodule

// File: tb/tb_stopwatch_multi.sv
// Bench for stopwatch_multi (DIGITS=4, TICK_DIV=4): directed scenarios then random
// button activity, all compared each cycle against an integer-arithmetic model.
module tb_stopwatch_multi;
    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int MODULUS  = 10000;

    localparam logic [3:0] B_SS  = 4'b1000;
    localparam logic [3:0] B_SET = 4'b0100;
    localparam logic [3:0] B_LAP = 4'b0010;
    localparam logic [3:0] B_CHG = 4'b0001;

    logic                clk;
    logic                rst_i;
    logic                start_stop_i, set_i, change_i, lap_i;
    logic [7*DIGITS-1:0] hex_o;
    logic                running_o, set_mode_o, lap_o;
    logic [2:0]          sel_o;

    int errors = 0;
    int checks = 0;

    stopwatch_multi #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
        .clk100_i     (clk),
        .rst_i        (rst_i),
        .start_stop_i (start_stop_i),
        .set_i        (set_i),
        .change_i     (change_i),
        .lap_i        (lap_i),
        .hex_o        (hex_o),
        .running_o    (running_o),
        .set_mode_o   (set_mode_o),
        .sel_o        (sel_o),
        .lap_o        (lap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0=stopped, 1=running, 2=setting; count is a plain integer.
    int       m_mode   = 0;
    int       m_count  = 0;
    int       m_presc  = 0;
    int       m_lapval = 0;
    int       m_sel    = 0;
    bit       m_lap    = 0;
    bit [3:0] h1 = '1, h2 = '1, h3 = '1;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    always @(posedge clk) begin
        bit [3:0] pr;
        int       p, d;
        if (rst_i) begin
            m_mode = 0; m_count = 0; m_presc = 0; m_lapval = 0; m_sel = 0; m_lap = 0;
            h1 = '1; h2 = '1; h3 = '1;
        end else begin
            // A press takes effect once it has been low for two earlier samples' worth of delay.
            pr = h3 & ~h2;
            h3 = h2;
            h2 = h1;
            h1 = {start_stop_i, set_i, lap_i, change_i};
            if (m_mode == 0) begin
                if (pr[3]) m_mode = 1;
                else if (pr[2]) begin m_mode = 2; m_sel = 0; end
                else if (pr[1]) begin
                    if (m_lap) m_lap = 0;
                    else begin m_count = 0; m_presc = 0; end
                end
            end else if (m_mode == 1) begin
                if (!pr[3] && pr[1]) begin
                    if (!m_lap) begin m_lap = 1; m_lapval = m_count; end
                    else m_lap = 0;
                end
                m_presc = m_presc + 1;
                if (m_presc == TICK_DIV) begin
                    m_presc = 0;
                    m_count = (m_count + 1) % MODULUS;
                end
                if (pr[3]) m_mode = 0;
            end else begin
                if (pr[2]) begin
                    if (m_sel == DIGITS - 1) begin m_mode = 0; m_sel = 0; end
                    else m_sel = m_sel + 1;
                end else if (pr[0]) begin
                    p = pow10(m_sel);
                    d = (m_count / p) % 10;
                    m_count = (d == 9) ? m_count - 9 * p : m_count + p;
                end
            end
        end
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  default: return 7'h10;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] hex_of(input int val);
        logic [7*DIGITS-1:0] h;
        int v;
        v = val;
        for (int k = 0; k < DIGITS; k++) begin
            h[7*k +: 7] = seg_of(v % 10);
            v = v / 10;
        end
        return h;
    endfunction

    task automatic check_all(input string tag);
        logic [7*DIGITS-1:0] eh;
        eh = hex_of(m_lap ? m_lapval : m_count);
        checks++;
        assert (hex_o === eh) else begin
            errors++; $error("FAIL %s hex_o got=%h exp=%h", tag, hex_o, eh);
        end
        checks++;
        assert (running_o === (m_mode == 1)) else begin
            errors++; $error("FAIL %s running_o got=%b exp=%b", tag, running_o, m_mode == 1);
        end
        checks++;
        assert (set_mode_o === (m_mode == 2)) else begin
            errors++; $error("FAIL %s set_mode_o got=%b exp=%b", tag, set_mode_o, m_mode == 2);
        end
        checks++;
        assert (sel_o === 3'(m_sel)) else begin
            errors++; $error("FAIL %s sel_o got=%0d exp=%0d", tag, sel_o, m_sel);
        end
        checks++;
        assert (lap_o === m_lap) else begin
            errors++; $error("FAIL %s lap_o got=%b exp=%b", tag, lap_o, m_lap);
        end
    endtask

    task automatic chk_hex(input string tag, input int val);
        logic [7*DIGITS-1:0] eh;
        eh = hex_of(val);
        checks++;
        assert (hex_o === eh) else begin
            errors++; $error("FAIL %s hex_o got=%h exp=%h", tag, hex_o, eh);
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++; $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic tick(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all(tag);
        end
    endtask

    task automatic drive(input logic [3:0] low_mask);
        {start_stop_i, set_i, lap_i, change_i} = ~low_mask;
    endtask

    // Holds the buttons low for three sampling edges; the effect lands on the third.
    task automatic press(input logic [3:0] m, input string tag);
        drive(m);
        tick(3, tag);
        drive(4'b0000);
    endtask

    task automatic tap(input logic [3:0] m, input string tag);
        press(m, tag);
        tick(2, tag);
    endtask

    int c;
    int f;

    initial begin
        rst_i = 1'b1;
        drive(4'b0000);
        tick(2, "reset");
        chk_hex("reset_zero", 0);
        rst_i = 1'b0;

        // One start press: 0001 after 4 running cycles, 0010 after 40.
        press(B_SS, "start");
        tick(4, "run4");
        chk_hex("count_0001", 1);
        tick(36, "run40");
        chk_hex("count_0010", 10);
        tap(B_SS, "stop1");
        tap(B_LAP, "clear1");
        chk_hex("cleared", 0);

        // Preset 0037 digit by digit, walking the selection off the top.
        tap(B_SET, "enter_set");
        for (int i = 0; i < 7; i++) tap(B_CHG, "chg_d0");
        tap(B_SET, "sel1");
        for (int i = 0; i < 3; i++) tap(B_CHG, "chg_d1");
        tap(B_SET, "sel2");
        tap(B_SET, "sel3");
        tap(B_SET, "exit_set");
        chk_hex("preset_0037", 37);
        chk_bit("set_mode_after_exit", set_mode_o, 1'b0);

        // Preload 9999 and check rollover to 0000 while still running.
        tap(B_LAP, "clear2");
        tap(B_SET, "enter_set2");
        for (int d = 0; d < DIGITS; d++) begin
            for (int i = 0; i < 9; i++) tap(B_CHG, "chg9");
            tap(B_SET, "next_digit");
        end
        chk_hex("preset_9999", 9999);
        press(B_SS, "start2");
        tick(4, "wrap4");
        chk_hex("wrap_0000", 0);
        chk_bit("running_after_wrap", running_o, 1'b1);

        // Lap freezes the display while the live count keeps going.
        tick(5, "pre_lap");
        press(B_LAP, "lap_on");
        chk_bit("lap_on", lap_o, 1'b1);
        f = m_lapval;
        tick(12, "lap_hold");
        chk_hex("lap_frozen", f);
        press(B_LAP, "lap_off");
        chk_bit("lap_off", lap_o, 1'b0);
        chk_hex("lap_live", m_count);

        // Stop press landing on the prescaler wrap still takes the final increment.
        for (int i = 0; i < 8 && m_presc != 1; i++) tick(1, "align");
        checks++;
        assert (m_presc == 1) else begin
            errors++; $error("FAIL align_timeout got=%0d exp=1", m_presc);
        end
        c = m_count;
        press(B_SS, "stop_on_wrap");
        chk_hex("final_increment", (c + 1) % MODULUS);
        chk_bit("stopped", running_o, 1'b0);
        tick(8, "frozen");
        chk_hex("still_frozen", (c + 1) % MODULUS);
        press(B_LAP, "idle_clear");
        chk_hex("idle_clear_0000", 0);
        tick(2, "gap");

        // start_stop beats set when both land together; reset mid-run.
        press(B_SS | B_SET, "ss_and_set");
        chk_bit("both_running", running_o, 1'b1);
        chk_bit("both_not_set", set_mode_o, 1'b0);
        tick(9, "run_before_rst");
        rst_i = 1'b1;
        tick(1, "rst_mid_run");
        chk_hex("rst_hex", 0);
        chk_bit("rst_running", running_o, 1'b0);
        chk_bit("rst_lap", lap_o, 1'b0);
        rst_i = 1'b0;
        tick(3, "post_rst");

        // Random button activity, occasional reset.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] m;
            for (int b = 0; b < 4; b++) m[b] = ($urandom_range(0, 5) == 0);
            drive(m);
            rst_i = ($urandom_range(0, 399) == 0);
            tick(1, "random");
        end
        rst_i = 1'b0;
        drive(4'b0000);
        tick(4, "drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
